// File: rtl/data_mem_responder.sv
// data_mem_responder: core data-port RAM with byte lanes plus MMIO page (TX FIFO, cycle counter, LED).
// Optional DMEM_MISALIGN_TRAP_EN suppresses misaligned accesses and raises a sticky err.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_F000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Load_size,
  output logic [31:0] ReadData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] led,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [31:0]   r_cycle;
  logic [15:0]   r_led;
  logic          w_ram, w_mmio, w_bad, w_we, w_full, w_pop, w_acc, w_ovf_set;
  logic [3:0]    w_be, w_reg_we;
  logic [31:0]   w_wd, w_word, w_reg, w_status;
  logic [AW-1:0] w_idx;
  assign w_ram     = Addr[31:AW+2] == '0;
  assign w_mmio    = Addr[31:4] == MMIO_BASE[31:4];
  assign w_idx     = Addr[AW+1:2];
  assign w_we      = MemWrite && !w_bad;
  assign w_reg_we  = {4{w_we && w_mmio}} & (4'b1 << Addr[3:2]);
  assign w_full    = r_count == CW'(FIFO_DEPTH);
  assign w_pop     = out_valid && out_ready;
  // A push into a full FIFO still lands when the head drains in the same cycle.
  assign w_acc     = w_reg_we[0] && (!w_full || w_pop);
  assign w_ovf_set = w_reg_we[0] && w_full && !w_pop;
  assign w_status  = {23'b0, r_ovf, 3'b0, w_full, 4'(r_count)};
  assign out_valid = r_count != '0;
  assign out_data  = out_valid ? r_fifo[r_rd] : 8'h00;
  assign led       = r_led;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;
  assign w_bad = (Load_size == 2'd0 && Addr[1:0] != 2'b00) || (Load_size == 2'd1 && Addr[0]);
  assign err   = r_err;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif
  always_comb begin
    w_reg    = Addr[3:2] == 2'd1 ? w_status : Addr[3:2] == 2'd2 ? r_cycle :
               Addr[3:2] == 2'd3 ? {16'b0, r_led} : 32'b0;
    w_word   = w_ram ? r_mem[w_idx] : w_mmio ? w_reg : 32'b0;
    ReadData = w_bad ? 32'b0 : Load_size == 2'd0 ? w_word :
               Load_size == 2'd1 ? {16'b0, w_word[{Addr[1], 4'b0} +: 16]} :
               {24'b0, w_word[{Addr[1:0], 3'b0} +: 8]};
    w_be     = Load_size == 2'd0 ? 4'hF : Load_size == 2'd1 ? (Addr[1] ? 4'hC : 4'h3) :
               4'b1 << Addr[1:0];
    w_wd     = Load_size == 2'd0 ? WriteData : Load_size == 2'd1 ? {2{WriteData[15:0]}} :
               {4{WriteData[7:0]}};
  end
  always_ff @(posedge CLK)
    if (w_we && w_ram)
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wd[8*k +: 8];
  always_ff @(posedge CLK)
    if (w_acc) r_fifo[r_wr] <= WriteData[7:0];
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_cycle <= 32'b0;
      r_led   <= 16'b0;
    end else begin
      if (w_acc) r_wr <= r_wr + FW'(1);
      if (w_pop) r_rd <= r_rd + FW'(1);
      r_count <= r_count + CW'(w_acc) - CW'(w_pop);
      r_ovf   <= w_ovf_set || (r_ovf && !(w_reg_we[1] && WriteData[8]));
      r_cycle <= w_reg_we[2] ? WriteData : r_cycle + 32'd1;
      if (w_reg_we[3]) r_led <= WriteData[15:0];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed + random checks against a byte-array / queue reference model.
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'hFFFF_F000;
  logic        CLK = 1'b0, Reset, MemWrite, out_ready, out_valid, err;
  logic [31:0] Addr, WriteData, ReadData;
  logic [1:0]  Load_size;
  logic [7:0]  out_data;
  logic [15:0] led;
  int n_cmp = 0, n_err = 0;
  logic [7:0]  m [0:4095];
  logic [7:0]  q [$];
  logic        m_ovf;
  logic [31:0] m_cyc;
  logic [15:0] m_led;

  data_mem_responder dut (
    .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
    .Load_size(Load_size), .ReadData(ReadData), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .led(led), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic rdy);
    MemWrite = we; Addr = a; WriteData = wd; Load_size = sz; out_ready = rdy;
    #1;
  endtask

  function automatic logic [31:0] exp_read();
    logic [31:0] w;
    int a;
    a = int'(Addr & ~32'd3);
    if (Addr < 32'h1000) w = {m[a+3], m[a+2], m[a+1], m[a]};
    else if (Addr >= BASE && Addr < BASE + 32'd16)
      case (Addr[3:2])
        2'd0: w = 0;
        2'd1: w = (32'(m_ovf) << 8) | (32'(q.size() == 4) << 4) | 32'(q.size());
        2'd2: w = m_cyc;
        default: w = {16'b0, m_led};
      endcase
    else w = 0;
    if (Load_size == 2'd0) return w;
    if (Load_size == 2'd1) return (w >> (16 * Addr[1])) & 32'hFFFF;
    return (w >> (8 * Addr[1:0])) & 32'hFF;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_rd"}, ReadData, exp_read());
    chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, "_data"}, 32'(out_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
    chk({tag, "_led"}, 32'(led), 32'(m_led));
  endtask

  task automatic tick();
    logic push, clr, cwr;
    int a;
    push = 0; clr = 0; cwr = 0;
    if (MemWrite) begin
      if (Addr < 32'h1000) begin
        if (Load_size == 2'd0) begin
          a = int'(Addr & ~32'd3);
          for (int k = 0; k < 4; k++) m[a+k] = WriteData[8*k +: 8];
        end else if (Load_size == 2'd1) begin
          a = int'(Addr & ~32'd1);
          for (int k = 0; k < 2; k++) m[a+k] = WriteData[8*k +: 8];
        end else m[int'(Addr)] = WriteData[7:0];
      end else if (Addr >= BASE && Addr < BASE + 32'd16)
        case (Addr[3:2])
          2'd0: push = 1;
          2'd1: clr = WriteData[8];
          2'd2: cwr = 1;
          default: m_led = WriteData[15:0];
        endcase
    end
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (clr) m_ovf = 0;
    if (push) begin
      if (q.size() < 4) q.push_back(WriteData[7:0]);
      else m_ovf = 1;
    end
    m_cyc = cwr ? WriteData : m_cyc + 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    MemWrite = 0; out_ready = 0;
    Reset = 1;
    #2;
    Reset = 0;
    q.delete(); m_ovf = 0; m_cyc = 0; m_led = 0;
    #1;
  endtask

  initial begin
    MemWrite = 0; Addr = 0; WriteData = 0; Load_size = 0; out_ready = 0;
    do_reset();
    drive(0, BASE + 4, 0, 0, 0);
    chk("rst_status", ReadData, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    drive(0, BASE + 8, 0, 0, 0);
    chk("rst_cycle", ReadData, 32'h0);
    for (int i = 0; i < 64; i++) begin
      drive(1, 32'(i * 4), $urandom, 0, 0);
      tick();
    end
    drive(1, 32'h10, 32'hDEADBEEF, 0, 0); tick();
    drive(0, 32'h10, 0, 2, 0); chk("ldb10", ReadData, 32'hEF);
    drive(0, 32'h11, 0, 2, 0); chk("ldb11", ReadData, 32'hBE);
    drive(0, 32'h12, 0, 3, 0); chk("ldb12", ReadData, 32'hAD);
    drive(0, 32'h13, 0, 2, 0); chk("ldb13", ReadData, 32'hDE);
    drive(0, 32'h12, 0, 1, 0); chk("ldh12", ReadData, 32'hDEAD);
    drive(1, 32'h11, 32'hFFFF_FF55, 2, 0); tick();
    drive(0, 32'h10, 0, 0, 0); chk("stb11", ReadData, 32'hDEAD55EF);
    drive(1, 32'h12, 32'hABCD_1234, 1, 0); tick();
    drive(0, 32'h10, 0, 0, 0); chk("sth12", ReadData, 32'h123455EF);
    drive(1, 32'h21, 32'hCAFEF00D, 0, 0); tick();
    drive(0, 32'h20, 0, 0, 0); chk("misal_w", ReadData, 32'hCAFEF00D);
    chk("misal_err", 32'(err), 32'd0);
    drive(0, 32'h1000, 0, 0, 0); chk("unmapped", ReadData, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, BASE, 32'(i), 0, 0);
      tick();
    end
    drive(0, BASE + 4, 0, 0, 0); chk("ovf_status", ReadData, 32'h114);
    for (int i = 1; i <= 4; i++) begin
      drive(0, BASE + 4, 0, 0, 1);
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(i));
      tick();
    end
    chk("drained", 32'(out_valid), 32'd0);
    drive(1, BASE + 4, 32'h100, 0, 0); tick();
    drive(0, BASE + 4, 0, 0, 0); chk("ovf_clr", ReadData, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1, BASE, 32'h11 + 32'(i), 0, 0);
      tick();
    end
    drive(1, BASE, 32'hAA, 0, 1);
    chk("fp_head", 32'(out_data), 32'h11);
    tick();
    drive(0, BASE + 4, 0, 0, 0); chk("fp_status", ReadData, 32'h014);
    for (int i = 0; i < 4; i++) begin
      drive(0, BASE + 4, 0, 0, 1);
      chk("fp_drain", 32'(out_data), i == 3 ? 32'hAA : 32'h12 + 32'(i));
      tick();
    end
    drive(1, BASE + 8, 32'hFFFF_FFFE, 0, 0); tick();
    drive(0, BASE + 8, 0, 0, 0); tick(); tick();
    chk("cyc_wrap", ReadData, 32'h0);
    drive(1, BASE + 12, 32'hA5A5_1234, 0, 0); tick();
    drive(0, BASE + 12, 0, 0, 0);
    chk("led_rd", ReadData, 32'h1234);
    chk("led_out", 32'(led), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      drive(1, BASE, 32'h70 + 32'(i), 0, 0);
      tick();
    end
    drive(0, BASE + 4, 0, 0, 1); tick();
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = r < 6 ? 32'($urandom_range(0, 255)) :
          r < 8 ? BASE + 32'($urandom_range(0, 15)) :
          r == 8 ? 32'h1000 + 32'($urandom_range(0, 15)) : 32'hFFFF_EFF0 + 32'($urandom_range(0, 15));
      drive($urandom_range(0, 2) == 0, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      check_outs("rnd");
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
